// File: rtl/mipi_csi_packet_extractor.sv
// -----------------------------------------------------------------------------
// mipi_csi_packet_extractor
//
// Sits between the lane aligner and the RAW unpackers in the MIPI byte-clock
// domain. It strips the CSI-2 long-packet header and CRC footer for 1, 2 or 4
// lanes. It filters long packets by data type and virtual channel. It marks the
// valid bytes of the final payload word with a per-byte enable. It also turns
// frame/line short packets into single-cycle strobes and flags payloads cut
// short by an early drop of data valid.
//
// Parameters
//   LANES           lane count (1, 2 or 4); data width is 8*LANES
//   DT_ACCEPT_MASK  bit n set accepts long-packet data type n
//   VC_ACCEPT_MASK  bit n set accepts virtual channel n
//
// Ports
//   clk_i           MIPI byte clock
//   reset_n_i       synchronous active-low reset
//   data_valid_i    lane-aligned data valid
//   data_i          aligned bytes, lane 0 = [7:0] = earliest byte
//   output_valid_o  data_o carries at least one payload byte
//   data_o          payload bytes, same byte order as data_i
//   byte_en_o       per-byte valid for data_o, bit 0 = lane 0
//   packet_type_o   data type of the current/last accepted long packet
//   vc_o            virtual channel of the current/last accepted long packet
//   word_count_o    word count of the current/last accepted long packet
//   frame_start_o   FS short-packet strobe
//   frame_end_o     FE short-packet strobe
//   line_start_o    LS short-packet strobe
//   line_end_o      LE short-packet strobe
//   frame_active_o  high between an accepted FS and its FE
//   trunc_err_o     pulse when an accepted payload ends before its last byte
//
// State  | meaning
// -------+------------------------------------------------------------------
// IDLE   | looking for the B8 sync byte in lane 0
// HDR    | collecting the 4 header bytes over 4/LANES beats
// PAYLOAD| forwarding payload bytes of an accepted long packet, then its CRC
// SKIP   | consuming payload and CRC of a rejected long packet silently
// -----------------------------------------------------------------------------
module mipi_csi_packet_extractor #(
    parameter int          LANES          = 4,
    parameter logic [63:0] DT_ACCEPT_MASK = 64'h0000_3C00_0000_0000,
    parameter logic [3:0]  VC_ACCEPT_MASK = 4'hF
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               data_valid_i,
    input  logic [8*LANES-1:0] data_i,
    output logic               output_valid_o,
    output logic [8*LANES-1:0] data_o,
    output logic [LANES-1:0]   byte_en_o,
    output logic [5:0]         packet_type_o,
    output logic [1:0]         vc_o,
    output logic [15:0]        word_count_o,
    output logic               frame_start_o,
    output logic               frame_end_o,
    output logic               line_start_o,
    output logic               line_end_o,
    output logic               frame_active_o,
    output logic               trunc_err_o
);

    localparam int          DW        = 8 * LANES;
    localparam int          HDR_BEATS = 4 / LANES;
    localparam logic [1:0]  HDR_LAST  = 2'(HDR_BEATS - 1);
    localparam logic [16:0] LANES_W   = 17'(LANES);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HDR     = 2'd1,
        S_PAYLOAD = 2'd2,
        S_SKIP    = 2'd3
    } state_t;

    state_t state_q;

    // Input stage
    logic [DW-1:0] d1_q;
    logic          v1_q;

    // Header assembly and payload byte accounting
    logic [31:0]      hdr_q;
    logic [31:0]      hdr_d;
    logic [1:0]       hdr_cnt_q;
    logic             hdr_done;
    logic [16:0]      rem_q;
    logic [16:0]      rem_d;
    logic [16:0]      avail;
    logic [16:0]      nbytes;
    logic [LANES-1:0] be_d;
    logic [5:0]       dt_d;
    logic [1:0]       vc_d;
    logic [15:0]      wc_d;
    logic             dt_ok;
    logic             vc_ok;

    // Registered outputs
    logic             out_valid_q;
    logic [DW-1:0]    data_q;
    logic [LANES-1:0] be_q;
    logic [5:0]       ptype_q;
    logic [1:0]       vc_q;
    logic [15:0]      wc_q;
    logic             fs_q;
    logic             fe_q;
    logic             ls_q;
    logic             le_q;
    logic             frame_act_q;
    logic             trunc_q;

    always_comb begin
        // New bytes enter at the top so the earliest byte ends up in [7:0]
        // once all header beats have been shifted in.
        hdr_d    = (hdr_q >> DW) | (32'(d1_q) << (32 - DW));
        hdr_done = (hdr_cnt_q == HDR_LAST);
        dt_d     = hdr_d[5:0];
        vc_d     = hdr_d[7:6];
        wc_d     = hdr_d[23:8];
        dt_ok    = DT_ACCEPT_MASK[dt_d];
        vc_ok    = VC_ACCEPT_MASK[vc_d];

        // rem counts payload plus the 2 CRC bytes still to come, so payload
        // bytes in this beat are whatever precedes the last two.
        avail  = (rem_q > 17'd2) ? (rem_q - 17'd2) : 17'd0;
        nbytes = (avail > LANES_W) ? LANES_W : avail;
        rem_d  = (rem_q > LANES_W) ? (rem_q - LANES_W) : 17'd0;

        be_d = '0;
        for (int i = 0; i < LANES; i++) begin
            be_d[i] = (17'(i) < nbytes);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q     <= S_IDLE;
            d1_q        <= '0;
            v1_q        <= 1'b0;
            hdr_q       <= '0;
            hdr_cnt_q   <= '0;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
            data_q      <= '0;
            be_q        <= '0;
            ptype_q     <= '0;
            vc_q        <= '0;
            wc_q        <= '0;
            fs_q        <= 1'b0;
            fe_q        <= 1'b0;
            ls_q        <= 1'b0;
            le_q        <= 1'b0;
            frame_act_q <= 1'b0;
            trunc_q     <= 1'b0;
        end else begin
            d1_q        <= data_i;
            v1_q        <= data_valid_i;
            data_q      <= d1_q;
            out_valid_q <= 1'b0;
            be_q        <= '0;
            fs_q        <= 1'b0;
            fe_q        <= 1'b0;
            ls_q        <= 1'b0;
            le_q        <= 1'b0;
            trunc_q     <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    hdr_cnt_q <= '0;
                    if (v1_q && (d1_q[7:0] == 8'hB8)) begin
                        state_q <= S_HDR;
                    end
                end

                S_HDR: begin
                    if (!v1_q) begin
                        state_q <= S_IDLE;
                    end else begin
                        hdr_q <= hdr_d;
                        if (!hdr_done) begin
                            hdr_cnt_q <= hdr_cnt_q + 2'd1;
                        end else begin
                            hdr_cnt_q <= '0;
                            if (dt_d <= 6'h0F) begin
                                state_q <= S_IDLE;
                                if (vc_ok) begin
                                    case (dt_d)
                                        6'h00: begin
                                            fs_q        <= 1'b1;
                                            frame_act_q <= 1'b1;
                                        end
                                        6'h01: begin
                                            fe_q        <= 1'b1;
                                            frame_act_q <= 1'b0;
                                        end
                                        6'h02:   ls_q <= 1'b1;
                                        6'h03:   le_q <= 1'b1;
                                        default: ;
                                    endcase
                                end
                            end else begin
                                rem_q <= {1'b0, wc_d} + 17'd2;
                                if (dt_ok && vc_ok) begin
                                    ptype_q <= dt_d;
                                    vc_q    <= vc_d;
                                    wc_q    <= wc_d;
                                    state_q <= S_PAYLOAD;
                                end else begin
                                    state_q <= S_SKIP;
                                end
                            end
                        end
                    end
                end

                S_PAYLOAD, S_SKIP: begin
                    if (!v1_q) begin
                        // Only a loss of real payload bytes counts as
                        // truncation; a lost CRC alone does not.
                        if ((state_q == S_PAYLOAD) && (rem_q > 17'd2)) begin
                            trunc_q <= 1'b1;
                        end
                        state_q <= S_IDLE;
                    end else begin
                        rem_q <= rem_d;
                        if (state_q == S_PAYLOAD) begin
                            out_valid_q <= (nbytes != 17'd0);
                            be_q        <= be_d;
                        end
                        if (rem_q <= LANES_W) begin
                            state_q <= S_IDLE;
                        end
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign output_valid_o = out_valid_q;
    assign data_o         = data_q;
    assign byte_en_o      = be_q;
    assign packet_type_o  = ptype_q;
    assign vc_o           = vc_q;
    assign word_count_o   = wc_q;
    assign frame_start_o  = fs_q;
    assign frame_end_o    = fe_q;
    assign line_start_o   = ls_q;
    assign line_end_o     = le_q;
    assign frame_active_o = frame_act_q;
    assign trunc_err_o    = trunc_q;

endmodule

// File: tb/tb_mipi_csi_packet_extractor.sv
module tb_mipi_csi_packet_extractor;

    typedef struct packed {
        logic        ov, fs, fe, ls, le, tr, fa;
        logic [3:0]  be;
        logic [31:0] data;
        logic [5:0]  pt;
        logic [1:0]  vc;
        logic [15:0] wc;
    } ev_t;

    int checks   = 0;
    int failures = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // 4-lane, default masks
    logic v4; logic [31:0] d4;
    logic ov4, fs4, fe4, ls4, le4, fa4, tr4;
    logic [31:0] do4; logic [3:0] be4; logic [5:0] pt4; logic [1:0] vc4; logic [15:0] wc4;
    // 2-lane, default masks
    logic v2; logic [15:0] d2;
    logic ov2, fs2, fe2, ls2, le2, fa2, tr2;
    logic [15:0] do2; logic [1:0] be2; logic [5:0] pt2; logic [1:0] vc2; logic [15:0] wc2;
    // 4-lane, VC0 only
    logic vv; logic [31:0] dv;
    logic ovv, fsv, fev, lsv, lev, fav, trv;
    logic [31:0] dov; logic [3:0] bev; logic [5:0] ptv; logic [1:0] vcv; logic [15:0] wcv;

    mipi_csi_packet_extractor #(.LANES(4)) u4 (
        .clk_i(clk), .reset_n_i(rst_n), .data_valid_i(v4), .data_i(d4),
        .output_valid_o(ov4), .data_o(do4), .byte_en_o(be4), .packet_type_o(pt4),
        .vc_o(vc4), .word_count_o(wc4), .frame_start_o(fs4), .frame_end_o(fe4),
        .line_start_o(ls4), .line_end_o(le4), .frame_active_o(fa4), .trunc_err_o(tr4));

    mipi_csi_packet_extractor #(.LANES(2)) u2 (
        .clk_i(clk), .reset_n_i(rst_n), .data_valid_i(v2), .data_i(d2),
        .output_valid_o(ov2), .data_o(do2), .byte_en_o(be2), .packet_type_o(pt2),
        .vc_o(vc2), .word_count_o(wc2), .frame_start_o(fs2), .frame_end_o(fe2),
        .line_start_o(ls2), .line_end_o(le2), .frame_active_o(fa2), .trunc_err_o(tr2));

    mipi_csi_packet_extractor #(.LANES(4), .VC_ACCEPT_MASK(4'b0001)) uv (
        .clk_i(clk), .reset_n_i(rst_n), .data_valid_i(vv), .data_i(dv),
        .output_valid_o(ovv), .data_o(dov), .byte_en_o(bev), .packet_type_o(ptv),
        .vc_o(vcv), .word_count_o(wcv), .frame_start_o(fsv), .frame_end_o(fev),
        .line_start_o(lsv), .line_end_o(lev), .frame_active_o(fav), .trunc_err_o(trv));

    ev_t q4[$];
    ev_t q2[$];
    ev_t qv[$];

    // Disabled bytes and identity fields of non-data events are don't care.
    function automatic ev_t mk_ev(logic ov, logic fs, logic fe, logic ls, logic le,
                                  logic tr, logic fa, logic [3:0] be, logic [31:0] d,
                                  logic [5:0] pt, logic [1:0] vc, logic [15:0] wc);
        ev_t e;
        e = '0;
        e.ov = ov; e.fs = fs; e.fe = fe; e.ls = ls; e.le = le; e.tr = tr; e.fa = fa;
        if (ov) begin
            e.be = be;
            for (int i = 0; i < 4; i++) begin
                if (be[i]) e.data[8*i +: 8] = d[8*i +: 8];
            end
            e.pt = pt; e.vc = vc; e.wc = wc;
        end
        return e;
    endfunction

    function automatic ev_t ev_dat(logic [3:0] be, logic [31:0] d, logic [5:0] pt,
                                   logic [1:0] vc, logic [15:0] wc, logic fa);
        return mk_ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, fa, be, d, pt, vc, wc);
    endfunction

    function automatic ev_t ev_sig(logic fs, logic fe, logic ls, logic le, logic tr, logic fa);
        return mk_ev(1'b0, fs, fe, ls, le, tr, fa, 4'h0, 32'h0, 6'h0, 2'h0, 16'h0);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic chk_ev(input string name, input ev_t got, input ev_t want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Monitor: every cycle in which a DUT shows any activity must match the
    // oldest expected event of that instance.
    always @(negedge clk) begin
        ev_t obs;
        if (ov4 | fs4 | fe4 | ls4 | le4 | tr4) begin
            obs = mk_ev(ov4, fs4, fe4, ls4, le4, tr4, fa4, be4, do4, pt4, vc4, wc4);
            if (q4.size() == 0) begin
                checks++; failures++;
                $display("FAIL u4_unexpected got=%h want=none", obs);
            end else chk_ev("u4_event", obs, q4.pop_front());
        end
        if (ov2 | fs2 | fe2 | ls2 | le2 | tr2) begin
            obs = mk_ev(ov2, fs2, fe2, ls2, le2, tr2, fa2, {2'b00, be2}, {16'h0, do2}, pt2, vc2, wc2);
            if (q2.size() == 0) begin
                checks++; failures++;
                $display("FAIL u2_unexpected got=%h want=none", obs);
            end else chk_ev("u2_event", obs, q2.pop_front());
        end
        if (ovv | fsv | fev | lsv | lev | trv) begin
            obs = mk_ev(ovv, fsv, fev, lsv, lev, trv, fav, bev, dov, ptv, vcv, wcv);
            if (qv.size() == 0) begin
                checks++; failures++;
                $display("FAIL uv_unexpected got=%h want=none", obs);
            end else chk_ev("uv_event", obs, qv.pop_front());
        end
    end

    task automatic b4(input logic v, input logic [31:0] d);
        v4 = v; d4 = d;
        @(posedge clk); #1;
    endtask

    task automatic b2(input logic v, input logic [15:0] d);
        v2 = v; d2 = d;
        @(posedge clk); #1;
    endtask

    task automatic bv(input logic v, input logic [31:0] d);
        vv = v; dv = d;
        @(posedge clk); #1;
    endtask

    localparam logic [31:0] SYNC4 = 32'hB8B8B8B8;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        v4 = 1'b0; d4 = '0; v2 = 1'b0; d2 = '0; vv = 1'b0; dv = '0;
        repeat (3) @(posedge clk);
        #1;

        // reset state
        chk("rst_valid", {31'h0, ov4}, 32'h0);
        chk("rst_data", do4, 32'h0);
        chk("rst_be", {28'h0, be4}, 32'h0);
        chk("rst_ptype", {26'h0, pt4}, 32'h0);
        chk("rst_vc", {30'h0, vc4}, 32'h0);
        chk("rst_wc", {16'h0, wc4}, 32'h0);
        chk("rst_strobes", {28'h0, fs4, fe4, ls4, le4}, 32'h0);
        chk("rst_fa_tr", {30'h0, fa4, tr4}, 32'h0);
        rst_n = 1'b1;
        b4(1'b0, 32'h0);

        // RAW10 WC=10: three beats, last with two payload bytes
        q4.push_back(ev_dat(4'hF, 32'h03020100, 6'h2B, 2'd0, 16'h000A, 1'b0));
        q4.push_back(ev_dat(4'hF, 32'h07060504, 6'h2B, 2'd0, 16'h000A, 1'b0));
        q4.push_back(ev_dat(4'h3, 32'h00000908, 6'h2B, 2'd0, 16'h000A, 1'b0));
        b4(1'b1, SYNC4);
        b4(1'b1, 32'h5A000A2B);
        b4(1'b1, 32'h03020100);
        b4(1'b1, 32'h07060504);
        b4(1'b1, 32'hCCCC0908);
        b4(1'b0, 32'h0);

        // short packets: FS, LS, generic (ignored), LE, FE
        q4.push_back(ev_sig(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        b4(1'b1, SYNC4); b4(1'b1, 32'h5A000100); b4(1'b0, 32'h0);
        q4.push_back(ev_sig(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
        b4(1'b1, SYNC4); b4(1'b1, 32'h5A000102); b4(1'b0, 32'h0);
        b4(1'b1, SYNC4); b4(1'b1, 32'h5A000108); b4(1'b0, 32'h0);
        q4.push_back(ev_sig(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
        b4(1'b1, SYNC4); b4(1'b1, 32'h5A000103); b4(1'b0, 32'h0);
        q4.push_back(ev_sig(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        b4(1'b1, SYNC4); b4(1'b1, 32'h5A000101); b4(1'b0, 32'h0);

        // rejected DT 0x12 WC=8, then RAW12 WC=6 back to back
        q4.push_back(ev_dat(4'hF, 32'h13121110, 6'h2C, 2'd0, 16'h0006, 1'b0));
        q4.push_back(ev_dat(4'h3, 32'h00001514, 6'h2C, 2'd0, 16'h0006, 1'b0));
        b4(1'b1, SYNC4);
        b4(1'b1, 32'h5A000812);
        b4(1'b1, 32'h000000B8);
        b4(1'b1, 32'h11223344);
        b4(1'b1, 32'h0000CCCC);
        b4(1'b1, SYNC4);
        b4(1'b1, 32'h5A00062C);
        b4(1'b1, 32'h13121110);
        b4(1'b1, 32'hC1C01514);
        b4(1'b0, 32'h0);

        // WC=0: CRC beat carries B8 in lane 0 and must not be taken as sync
        b4(1'b1, SYNC4);
        b4(1'b1, 32'h5A00002A);
        b4(1'b1, 32'h0000C0B8);
        b4(1'b1, 32'h5A000400);
        b4(1'b0, 32'h0);
        b4(1'b0, 32'h0);
        chk("wc0_ptype", {26'h0, pt4}, 32'h0000002A);
        chk("wc0_wc", {16'h0, wc4}, 32'h0);

        // truncation after 1 of 3 payload beats
        q4.push_back(ev_dat(4'hF, 32'h23222120, 6'h2A, 2'd0, 16'h000A, 1'b0));
        q4.push_back(ev_sig(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        b4(1'b1, SYNC4);
        b4(1'b1, 32'h5A000A2A);
        b4(1'b1, 32'h23222120);
        b4(1'b0, 32'h0);
        b4(1'b0, 32'h0);
        b4(1'b0, 32'h0);

        // FS, then reset in the middle of a payload
        q4.push_back(ev_sig(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        b4(1'b1, SYNC4); b4(1'b1, 32'h5A000200); b4(1'b0, 32'h0);
        q4.push_back(ev_dat(4'hF, 32'h33323130, 6'h2A, 2'd0, 16'h000A, 1'b1));
        b4(1'b1, SYNC4);
        b4(1'b1, 32'h5A000A2A);
        b4(1'b1, 32'h33323130);
        b4(1'b1, 32'h37363534);
        rst_n = 1'b0;
        b4(1'b1, 32'h3B3A3938);
        chk("midrst_valid", {31'h0, ov4}, 32'h0);
        chk("midrst_data", do4, 32'h0);
        chk("midrst_ptype_wc", {10'h0, pt4, wc4}, 32'h0);
        chk("midrst_fa", {31'h0, fa4}, 32'h0);
        rst_n = 1'b1;
        b4(1'b0, 32'h0);

        // normal decode after reset, VC1
        q4.push_back(ev_dat(4'hF, 32'h43424140, 6'h2B, 2'd1, 16'h0004, 1'b0));
        b4(1'b1, SYNC4);
        b4(1'b1, 32'h5A00046B);
        b4(1'b1, 32'h43424140);
        b4(1'b1, 32'h0000C1C0);
        b4(1'b0, 32'h0);

        // 2 lanes: RAW10 WC=5 -> 11, 11, 01, then a CRC-only beat
        q2.push_back(ev_dat(4'h3, 32'h00002120, 6'h2B, 2'd0, 16'h0005, 1'b0));
        q2.push_back(ev_dat(4'h3, 32'h00002322, 6'h2B, 2'd0, 16'h0005, 1'b0));
        q2.push_back(ev_dat(4'h1, 32'h00000024, 6'h2B, 2'd0, 16'h0005, 1'b0));
        b2(1'b1, 16'hB8B8);
        b2(1'b1, 16'h052B);
        b2(1'b1, 16'h5A00);
        b2(1'b1, 16'h2120);
        b2(1'b1, 16'h2322);
        b2(1'b1, 16'hC024);
        b2(1'b1, 16'h00C1);
        b2(1'b0, 16'h0);
        q2.push_back(ev_sig(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        b2(1'b1, 16'hB8B8);
        b2(1'b1, 16'h0002);
        b2(1'b1, 16'h5A00);
        b2(1'b0, 16'h0);

        // VC filter: VC2 long and short packets dropped, VC0 extracted
        bv(1'b1, SYNC4);
        bv(1'b1, 32'h5A0004AB);
        bv(1'b1, 32'h33323130);
        bv(1'b1, 32'h0000C1C0);
        bv(1'b0, 32'h0);
        bv(1'b1, SYNC4);
        bv(1'b1, 32'h5A000180);
        bv(1'b0, 32'h0);
        qv.push_back(ev_dat(4'hF, 32'h33323130, 6'h2B, 2'd0, 16'h0004, 1'b0));
        bv(1'b1, SYNC4);
        bv(1'b1, 32'h5A00042B);
        bv(1'b1, 32'h33323130);
        bv(1'b1, 32'h0000C1C0);
        bv(1'b0, 32'h0);

        repeat (8) @(posedge clk);
        #1;
        chk("u4_pending", q4.size(), 32'h0);
        chk("u2_pending", q2.size(), 32'h0);
        chk("uv_pending", qv.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
